// File: rtl/button_reader.sv
// Debounces N_BTN raw buttons and emits press/release/long events as pulses and as a valid-ready stream.
// Latency: BTN edge to STATE/PRESS is 2+DEBOUNCE_CYCLES cycles; a pending event reaches EV_VALID one cycle later.
// Backpressure: EV_CODE is held while EV_READY=0. An event that finds its pending bit busy is dropped and sets OVERFLOW.
//
// Ports:
//   CLK, RST_N        single clock (rising edge), asynchronous active-low reset
//   BTN               raw asynchronous button levels, active-high
//   STATE             debounced button levels
//   PRESS/RELEASE/LONG one-cycle event pulses per button
//   EV_VALID/EV_READY/EV_CODE  event stream, EV_CODE = {type[1:0], index}
//                     type 01 press, 10 release, 11 long
//   OVERFLOW          sticky lost-event flag, cleared only by reset
//
// Build option: define BUTTON_READER_LONG_PRESS_EN to include the held-time counters,
// the LONG pulses and the type-11 events. Without it, LONG is tied to 0.
module button_reader #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000,
  localparam int unsigned IW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N_BTN-1:0]  BTN,
  output logic [N_BTN-1:0]  STATE,
  output logic [N_BTN-1:0]  PRESS,
  output logic [N_BTN-1:0]  RELEASE,
  output logic [N_BTN-1:0]  LONG,
  output logic              EV_VALID,
  input  logic              EV_READY,
  output logic [IW+1:0]     EV_CODE,
  output logic              OVERFLOW
);

  if (N_BTN < 1 || N_BTN > 16 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
    $error("button_reader: parameter out of range");
  end

  localparam logic [1:0] TYPE_PRESS = 2'b01;
  localparam logic [1:0] TYPE_REL   = 2'b10;
  localparam logic [1:0] TYPE_LONG  = 2'b11;

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [DW-1:0]    db_cnt [N_BTN];

  logic [N_BTN-1:0] db_done;
  logic [N_BTN-1:0] press_set;
  logic [N_BTN-1:0] rel_set;
  logic [N_BTN-1:0] long_set;

  // ---------------------------------------------------------------
  // Synchronizer and debounce
  // ---------------------------------------------------------------
  // db_done marks the edge on which the DEBOUNCE_CYCLES-th consecutive
  // differing sample is seen; STATE flips and the counter clears there.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      db_done[i] = (sync2[i] != STATE[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  assign press_set = db_done & sync2;
  assign rel_set   = db_done & ~sync2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1   <= '0;
      sync2   <= '0;
      STATE   <= '0;
      PRESS   <= '0;
      RELEASE <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1   <= BTN;
      sync2   <= sync1;
      STATE   <= STATE ^ db_done;
      PRESS   <= press_set;
      RELEASE <= rel_set;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == STATE[i] || db_done[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Long-press detection
  // ---------------------------------------------------------------
`ifdef BUTTON_READER_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_cnt [N_BTN];

  // The count saturates at LONG_CYCLES, so the reach-condition fires only
  // once per press; a release clears it for the next press.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      long_set[i] = STATE[i] && (hold_cnt[i] == HOLD_LAST);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LONG <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      LONG <= long_set;
      for (int i = 0; i < N_BTN; i++) begin
        if (!STATE[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != HOLD_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + HW'(1);
        end
      end
    end
  end
`else
  assign long_set = '0;
  assign LONG     = '0;
`endif

  // ---------------------------------------------------------------
  // Pending bits and event stream
  // ---------------------------------------------------------------
  logic [N_BTN-1:0] pend_press;
  logic [N_BTN-1:0] pend_rel;
  logic [N_BTN-1:0] pend_long;
  logic [N_BTN-1:0] avail_press;
  logic [N_BTN-1:0] avail_rel;
  logic [N_BTN-1:0] avail_long;
  logic             xfer;
  logic             sel_vld;
  logic [IW+1:0]    sel_code;
  logic             ovf_hit;

  assign xfer = EV_VALID && EV_READY;

  // The presented event keeps its pending bit set until it transfers.
  // avail_* is the pending set with the transferring event removed, which
  // is both what remains pending and what may be presented next.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      logic hit;
      hit            = xfer && (EV_CODE[IW-1:0] == IW'(i));
      avail_press[i] = pend_press[i] && !(hit && EV_CODE[IW+1:IW] == TYPE_PRESS);
      avail_rel[i]   = pend_rel[i]   && !(hit && EV_CODE[IW+1:IW] == TYPE_REL);
      avail_long[i]  = pend_long[i]  && !(hit && EV_CODE[IW+1:IW] == TYPE_LONG);
    end
  end

  // Descending scan so the lowest index wins; within one button the later
  // assignment wins, giving press over long over release.
  always_comb begin
    sel_vld  = 1'b0;
    sel_code = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (avail_rel[i]) begin
        sel_vld  = 1'b1;
        sel_code = {TYPE_REL, IW'(i)};
      end
      if (avail_long[i]) begin
        sel_vld  = 1'b1;
        sel_code = {TYPE_LONG, IW'(i)};
      end
      if (avail_press[i]) begin
        sel_vld  = 1'b1;
        sel_code = {TYPE_PRESS, IW'(i)};
      end
    end
  end

  // A new event on a bit still pending (and not leaving this edge) is lost.
  assign ovf_hit = |((press_set & avail_press) | (rel_set & avail_rel) | (long_set & avail_long));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_press <= '0;
      pend_rel   <= '0;
      pend_long  <= '0;
      EV_VALID   <= 1'b0;
      EV_CODE    <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      // Set wins over a same-edge clear, so the event is re-presented.
      pend_press <= avail_press | press_set;
      pend_rel   <= avail_rel   | rel_set;
      pend_long  <= avail_long  | long_set;
      if (ovf_hit) begin
        OVERFLOW <= 1'b1;
      end
      if (!EV_VALID || EV_READY) begin
        EV_VALID <= sel_vld;
        EV_CODE  <= sel_code;
      end
    end
  end

endmodule

// File: tb/tb_button_reader.sv
module tb_button_reader;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [4:0] BTN = '0;
  logic       EV_READY = 1'b0;
  logic [4:0] STATE;
  logic [4:0] PRESS;
  logic [4:0] RELEASE;
  logic [4:0] LONG;
  logic       EV_VALID;
  logic [4:0] EV_CODE;
  logic       OVERFLOW;

`ifdef BUTTON_READER_LONG_PRESS_EN
  localparam int LONG_EN = 1;
`else
  localparam int LONG_EN = 0;
`endif

  always #5 CLK = ~CLK;

  button_reader #(
    .N_BTN(5),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(16)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .BTN(BTN),
    .STATE(STATE),
    .PRESS(PRESS),
    .RELEASE(RELEASE),
    .LONG(LONG),
    .EV_VALID(EV_VALID),
    .EV_READY(EV_READY),
    .EV_CODE(EV_CODE),
    .OVERFLOW(OVERFLOW)
  );

  int n_cmp = 0;
  int n_err = 0;
  int press_cnt [5];
  int rel_cnt [5];
  int long_cnt [5];
  logic [4:0] xq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records a transfer using the values the coming edge will see, then
  // advances one cycle and samples 1 time unit after the edge.
  task automatic tick();
    if (EV_VALID === 1'b1 && EV_READY === 1'b1) xq.push_back(EV_CODE);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      press_cnt[i] += int'(PRESS[i]);
      rel_cnt[i]   += int'(RELEASE[i]);
      long_cnt[i]  += int'(LONG[i]);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset(input string tag);
    RST_N = 1'b0;
    BTN = '0;
    EV_READY = 1'b0;
    ticks(2);
    chk({tag, "_rst_state"}, STATE, 0);
    chk({tag, "_rst_pulses"}, {PRESS, RELEASE, LONG}, 0);
    chk({tag, "_rst_ev"}, {EV_VALID, EV_CODE, OVERFLOW}, 0);
    RST_N = 1'b1;
    xq.delete();
    for (int i = 0; i < 5; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i] = 0;
      long_cnt[i] = 0;
    end
  endtask

  initial begin
    // A: clean press and release of button 0, stream always ready
    do_reset("A");
    EV_READY = 1'b1;
    BTN[0] = 1'b1;
    ticks(5);
    chk("A_state_early", STATE, 5'b00000);
    tick();
    chk("A_state_rise", STATE, 5'b00001);
    chk("A_press", PRESS, 5'b00001);
    tick();
    chk("A_press_end", PRESS, 5'b00000);
    chk("A_ev_valid", EV_VALID, 1);
    chk("A_ev_code", EV_CODE, 5'b01000);
    tick();
    chk("A_ev_done", EV_VALID, 0);
    ticks(4);
    chk("A_press_cnt", press_cnt[0], 1);
    chk("A_xq_size", xq.size(), 1);
    chk("A_xq0", xq[0], 5'b01000);
    BTN[0] = 1'b0;
    ticks(5);
    chk("A_state_hold", STATE, 5'b00001);
    tick();
    chk("A_state_fall", STATE, 5'b00000);
    chk("A_release", RELEASE, 5'b00001);
    tick();
    chk("A_rel_valid", EV_VALID, 1);
    chk("A_rel_code", EV_CODE, 5'b10000);

    // B: button 2 bouncing every 2 cycles, then held
    do_reset("B");
    EV_READY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      BTN[2] = (k % 2 == 0);
      ticks(2);
    end
    chk("B_no_press_in_bounce", press_cnt[2], 0);
    BTN[2] = 1'b1;
    ticks(12);
    chk("B_press_cnt", press_cnt[2], 1);
    chk("B_rel_cnt", rel_cnt[2], 0);
    chk("B_state", STATE, 5'b00100);
    chk("B_xq_size", xq.size(), 1);
    chk("B_xq0", xq[0], 5'b01010);

    // C: simultaneous presses of buttons 0 and 3 under backpressure
    do_reset("C");
    BTN = 5'b01001;
    ticks(8);
    chk("C_hold_code_early", {EV_VALID, EV_CODE}, 6'b1_01000);
    ticks(2);
    chk("C_hold_valid", EV_VALID, 1);
    chk("C_hold_code", EV_CODE, 5'b01000);
    EV_READY = 1'b1;
    tick();
    chk("C_next_valid", EV_VALID, 1);
    chk("C_next_code", EV_CODE, 5'b01011);
    tick();
    chk("C_drained", EV_VALID, 0);
    chk("C_xq_size", xq.size(), 2);
    chk("C_xq0", xq[0], 5'b01000);
    chk("C_xq1", xq[1], 5'b01011);

    // D: press, release, press on button 1 with the stream stalled
    do_reset("D");
    BTN[1] = 1'b1;
    ticks(8);
    BTN[1] = 1'b0;
    ticks(8);
    chk("D_no_ovf_yet", OVERFLOW, 0);
    chk("D_stalled_code", {EV_VALID, EV_CODE}, 6'b1_01001);
    BTN[1] = 1'b1;
    ticks(8);
    chk("D_ovf", OVERFLOW, 1);
    EV_READY = 1'b1;
    ticks(6);
    chk("D_xq_size", xq.size(), 2);
    chk("D_xq0", xq[0], 5'b01001);
    chk("D_xq1", xq[1], 5'b10001);
    chk("D_ovf_sticky", OVERFLOW, 1);
    chk("D_drained", EV_VALID, 0);

    // E: button 4 held for 40 cycles
    do_reset("E");
    EV_READY = 1'b1;
    BTN[4] = 1'b1;
    ticks(6);
    chk("E_state_rise", STATE, 5'b10000);
    ticks(15);
    chk("E_long_early", LONG, 5'b00000);
    tick();
    chk("E_long_pulse", LONG, (LONG_EN != 0) ? 5'b10000 : 5'b00000);
    tick();
    chk("E_long_end", LONG, 5'b00000);
    ticks(17);
    chk("E_long_cnt", long_cnt[4], LONG_EN);
    chk("E_xq_size", xq.size(), 1 + LONG_EN);
    chk("E_xq_last", xq[xq.size() - 1], (LONG_EN != 0) ? 5'b11100 : 5'b01100);

    // F: reset pulsed while button 0 is held and its event is pending
    do_reset("F");
    BTN[0] = 1'b1;
    ticks(10);
    chk("F_pending_before", {EV_VALID, EV_CODE}, 6'b1_01000);
    RST_N = 1'b0;
    #1;
    chk("F_async_clear", {STATE, EV_VALID, EV_CODE, OVERFLOW}, 0);
    ticks(2);
    chk("F_in_rst_state", STATE, 0);
    chk("F_in_rst_pulses", {PRESS, RELEASE, LONG}, 0);
    chk("F_in_rst_ev", {EV_VALID, EV_CODE, OVERFLOW}, 0);
    RST_N = 1'b1;
    ticks(5);
    chk("F_press_early", PRESS, 5'b00000);
    chk("F_no_stale_ev", EV_VALID, 0);
    tick();
    chk("F_press", PRESS, 5'b00001);
    tick();
    chk("F_ev", {EV_VALID, EV_CODE}, 6'b1_01000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 SHALL have parameter N_BTN, default 5: number of raw push-button inputs (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stable cycles needed to accept a level change (10 ms at 100 MHz).
REQ-003 SHALL have parameter LONG_CYCLES, default 100000000: held cycles that make a long press (1 s at 100 MHz).
REQ-004 SHALL have port CLK, input, 1: the single clock; all flops on its rising edge.
REQ-005 SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port BTN, input, N_BTN: raw asynchronous button levels, active-high.
REQ-007 SHALL have port STATE, output, N_BTN: debounced button levels.
REQ-008 SHALL have ports PRESS, RELEASE and LONG, output, N_BTN each: one-cycle event pulses.
REQ-009 SHALL have ports EV_VALID (out, 1), EV_READY (in, 1) and EV_CODE (out, 2+IW, IW=max(1,clog2(N_BTN))): event stream, EV_CODE={type[1:0],index}.
REQ-010 SHALL have port OVERFLOW, output, 1: sticky lost-event flag.

Function
REQ-011 SHALL pass each BTN bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep a per-button counter that increments while the synchronized bit differs from STATE and clears whenever they are equal.
REQ-013 SHALL update STATE[i] and clear its counter on the edge where DEBOUNCE_CYCLES consecutive differing samples have been seen; latency from a clean BTN edge to STATE is 2+DEBOUNCE_CYCLES cycles.
REQ-014 SHALL assert PRESS[i] (RELEASE[i]) for exactly the first cycle in which STATE[i] reads 1 (0) after a change.
REQ-015 SHALL generate no event from glitches shorter than DEBOUNCE_CYCLES, including periodic bounce.
REQ-016 SHALL count held cycles per button while STATE[i]=1, saturating, and clear the count when STATE[i]=0.
REQ-017 SHALL pulse LONG[i] once, in the cycle the held count reaches LONG_CYCLES, with no repeat until a release followed by a new press.
REQ-018 SHALL keep one pending bit per button per event type; type codes are 01 press, 10 release, 11 long.
REQ-019 SHALL select the lowest button index first, then press, long, release, and SHALL load the selection into registered EV_CODE, asserting EV_VALID one cycle after the pending bit sets.
REQ-020 SHALL transfer on any edge with EV_VALID=1 and EV_READY=1, clearing that pending bit; the next pending event appears the following cycle, giving back-to-back throughput of 1 per cycle.
REQ-021 SHALL hold EV_CODE stable while EV_VALID=1 and EV_READY=0, even if a higher-priority event arrives.
REQ-022 SHALL let set win over clear when a new event hits the same pending bit on its transfer edge, so the event is re-presented.
REQ-023 SHALL set OVERFLOW and drop the new event when an event hits a pending bit that is already set and not being transferred; OVERFLOW is cleared only by reset.

Reset
REQ-024 SHALL, while RST_N=0, force synchronizers, counters, pending bits, STATE, PRESS, RELEASE, LONG, EV_VALID, EV_CODE and OVERFLOW to 0.
REQ-025 SHALL discard pending events on reset asserted mid-operation; a button held through reset release yields a PRESS 2+DEBOUNCE_CYCLES cycles later.

Configuration
REQ-026 SHALL include the long-press counters, LONG pulses and type-11 events only when BUTTON_READER_LONG_PRESS_EN is defined.
REQ-027 SHALL, without BUTTON_READER_LONG_PRESS_EN, tie LONG to 0, never emit type 11, and instantiate no held counters.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, N_BTN=5)
REQ-028 SHALL check a clean BTN[0] rise, held, EV_READY=1 -> STATE[0] rises exactly 6 cycles later; one PRESS[0] pulse; EV_CODE=01_000 is valid for one cycle.
REQ-029 SHALL check BTN[2] toggling every 2 cycles for 20 cycles, then held at 1 -> exactly one PRESS[2], no RELEASE[2].
REQ-030 SHALL check simultaneous BTN[0] and BTN[3] presses with EV_READY=0 for 10 cycles, then 1 -> EV_CODE holds 01_000, then 01_000 and 01_011 transfer on consecutive cycles.
REQ-031 SHALL check BTN[1] press, release, press, each 8 cycles stable, with EV_READY=0 -> OVERFLOW=1 and exactly 2 events delivered afterwards (press, release).
REQ-032 SHALL check BTN[4] held 40 cycles with the macro defined -> one LONG[4] pulse 16 cycles after STATE[4] rises; the same test without the macro -> LONG stays 0.
REQ-033 SHALL check RST_N pulsed low mid-hold of BTN[0], with BTN[0] kept at 1 -> all outputs 0 during reset; PRESS[0] occurs 6 cycles after RST_N rises.
